seg7_scan_driver: RTL and testbench

SEG7_SCAN_DRIVER -- requirements
Module: seg7_scan_driver

---
 rtl/seg7_scan_driver.sv | 152 +++++++++++++++
 tb/tb_seg7_scan_driver.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/seg7_scan_driver.sv
// rtl/seg7_scan_driver.sv - multiplexed 4-digit seven-segment scan driver with anti-ghosting gaps
module seg7_scan_driver #(
    parameter int ON_CYC  = 50000,
    parameter int GAP_CYC = 500
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    input  logic [15:0] value_in,
    input  logic        load,
    input  logic [3:0]  blank_mask,
    output logic [6:0]  seg_n,
    output logic [3:0]  an_n,
    output logic        frame_tick
);

    localparam int MAX_CYC = (ON_CYC > GAP_CYC) ? ON_CYC : GAP_CYC;
    localparam int CW      = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

    localparam logic [6:0] SEG_DARK = 7'h7F;
    localparam logic [3:0] AN_DARK  = 4'hF;

    typedef enum logic [1:0] {
        ST_OFF,
        ST_GAP,
        ST_ON
    } state_t;

    state_t      state_q;
    logic [1:0]  idx_q;
    logic [CW-1:0] cnt_q;
    logic [15:0] pend_q;
    logic [15:0] disp_q;
    logic [6:0]  seg_n_q;
    logic [3:0]  an_n_q;
    logic        frame_tick_q;

    logic [15:0] pend_d;
    logic [15:0] disp_d;
    logic        gap_last;
    logic        on_last;
    logic        boundary;
    logic [3:0]  nib;
    logic [3:0]  lit_an;
    logic [6:0]  lit_seg;
    logic        blanked;

    function automatic logic [6:0] decode(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'h0: s = 7'h40;
            4'h1: s = 7'h79;
            4'h2: s = 7'h24;
            4'h3: s = 7'h30;
            4'h4: s = 7'h19;
            4'h5: s = 7'h12;
            4'h6: s = 7'h02;
            4'h7: s = 7'h78;
            4'h8: s = 7'h00;
            4'h9: s = 7'h10;
            4'hA: s = 7'h08;
            4'hB: s = 7'h03;
            4'hC: s = 7'h46;
            4'hD: s = 7'h21;
            4'hE: s = 7'h06;
            default: s = 7'h0E;
        endcase
        return s;
    endfunction

    // A load coinciding with a display update bypasses pend so it is never lost for a frame.
    always_comb begin
        gap_last = (cnt_q == CW'(GAP_CYC - 1));
        on_last  = (cnt_q == CW'(ON_CYC - 1));
        boundary = (state_q == ST_ON) && (idx_q == 2'd3) && on_last;
        pend_d   = load ? value_in : pend_q;
        disp_d   = ((state_q == ST_OFF) || boundary) ? pend_d : disp_q;
        nib      = disp_q[{idx_q, 2'b00} +: 4];
        lit_an   = ~(4'b0001 << idx_q);
        lit_seg  = decode(nib);
        blanked  = blank_mask[idx_q];
    end

    // Outputs are assigned for the state being entered, so they line up with that state's cycles.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q      <= ST_OFF;
            idx_q        <= 2'd0;
            cnt_q        <= '0;
            pend_q       <= '0;
            disp_q       <= '0;
            seg_n_q      <= SEG_DARK;
            an_n_q       <= AN_DARK;
            frame_tick_q <= 1'b0;
        end else begin
            pend_q       <= pend_d;
            disp_q       <= disp_d;
            seg_n_q      <= SEG_DARK;
            an_n_q       <= AN_DARK;
            frame_tick_q <= 1'b0;
            if (!enable) begin
                state_q <= ST_OFF;
                idx_q   <= 2'd0;
                cnt_q   <= '0;
            end else begin
                case (state_q)
                    ST_OFF: begin
                        state_q <= ST_GAP;
                        idx_q   <= 2'd0;
                        cnt_q   <= '0;
                    end
                    ST_GAP: begin
                        if (gap_last) begin
                            state_q <= ST_ON;
                            cnt_q   <= '0;
                            if (!blanked) begin
                                an_n_q  <= lit_an;
                                seg_n_q <= lit_seg;
                            end
                        end else begin
                            cnt_q <= cnt_q + CW'(1);
                        end
                    end
                    ST_ON: begin
                        if (on_last) begin
                            state_q      <= ST_GAP;
                            cnt_q        <= '0;
                            idx_q        <= idx_q + 2'd1;
                            frame_tick_q <= (idx_q == 2'd3);
                        end else begin
                            cnt_q <= cnt_q + CW'(1);
                            if (!blanked) begin
                                an_n_q  <= lit_an;
                                seg_n_q <= lit_seg;
                            end
                        end
                    end
                    default: begin
                        state_q <= ST_OFF;
                        idx_q   <= 2'd0;
                        cnt_q   <= '0;
                    end
                endcase
            end
        end
    end

    assign seg_n      = seg_n_q;
    assign an_n       = an_n_q;
    assign frame_tick = frame_tick_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// tb/tb_seg7_scan_driver.sv - randomized bench for seg7_scan_driver against a frame-position model
module tb_seg7_scan_driver;

    localparam int ON    = 4;
    localparam int GAP   = 2;
    localparam int SLOT  = ON + GAP;
    localparam int FRAME = 4 * SLOT;

    logic        clk = 1'b0;
    logic        reset;
    logic        enable;
    logic [15:0] value_in;
    logic        load;
    logic [3:0]  blank_mask;
    logic [6:0]  seg_n;
    logic [3:0]  an_n;
    logic        frame_tick;

    always #5 clk = ~clk;

    seg7_scan_driver #(.ON_CYC(ON), .GAP_CYC(GAP)) dut (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable),
        .value_in   (value_in),
        .load       (load),
        .blank_mask (blank_mask),
        .seg_n      (seg_n),
        .an_n       (an_n),
        .frame_tick (frame_tick)
    );

    int checks = 0;
    int errors = 0;
    int ticks  = 0;

    bit          m_run;
    int          m_t;
    logic [15:0] m_pend;
    logic [15:0] m_disp;
    logic [6:0]  dec_tab [16];
    logic [6:0]  exp_seg;
    logic [3:0]  exp_an;
    logic        exp_ft;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Model tracks the position within a 24-cycle frame rather than any FSM state.
    task automatic model_step();
        bit boundary;
        int slot;
        int ofs;
        exp_an  = 4'hF;
        exp_seg = 7'h7F;
        exp_ft  = 1'b0;
        if (!reset) begin
            m_run  = 0;
            m_t    = 0;
            m_pend = '0;
            m_disp = '0;
        end else begin
            boundary = m_run && (m_t == FRAME - 1);
            if (load) m_pend = value_in;
            if (!m_run || boundary) m_disp = m_pend;
            if (!enable) begin
                m_run = 0;
                m_t   = 0;
            end else if (!m_run) begin
                m_run = 1;
                m_t   = 0;
            end else begin
                m_t = (m_t + 1) % FRAME;
            end
            if (m_run) begin
                exp_ft = boundary && (m_t == 0);
                slot = m_t / SLOT;
                ofs  = m_t % SLOT;
                if (ofs >= GAP && !blank_mask[slot]) begin
                    exp_an  = ~(4'b0001 << slot);
                    exp_seg = dec_tab[m_disp[slot*4 +: 4]];
                end
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_step();
        #1;
        check("an_n", {28'd0, an_n}, {28'd0, exp_an});
        check("seg_n", {25'd0, seg_n}, {25'd0, exp_seg});
        check("frame_tick", {31'd0, frame_tick}, {31'd0, exp_ft});
        check("an_one_cold", {31'd0, (an_n == 4'hF) || ($countones(~an_n) == 1)}, 32'd1);
        if (frame_tick) ticks++;
    endtask

    task automatic run_until_slot(input int s);
        int i;
        i = 0;
        while (i < 2 * FRAME && !(m_run && (m_t / SLOT == s) && (m_t % SLOT == GAP))) begin
            step();
            i++;
        end
        check("reach_slot", {31'd0, m_run && (m_t / SLOT == s) && (m_t % SLOT == GAP)}, 32'd1);
    endtask

    initial begin
        dec_tab[0]  = 7'h40; dec_tab[1]  = 7'h79; dec_tab[2]  = 7'h24; dec_tab[3]  = 7'h30;
        dec_tab[4]  = 7'h19; dec_tab[5]  = 7'h12; dec_tab[6]  = 7'h02; dec_tab[7]  = 7'h78;
        dec_tab[8]  = 7'h00; dec_tab[9]  = 7'h10; dec_tab[10] = 7'h08; dec_tab[11] = 7'h03;
        dec_tab[12] = 7'h46; dec_tab[13] = 7'h21; dec_tab[14] = 7'h06; dec_tab[15] = 7'h0E;
        m_run = 0; m_t = 0; m_pend = '0; m_disp = '0;

        reset = 1'b0; enable = 1'b0; load = 1'b0; value_in = '0; blank_mask = '0;
        repeat (3) step();
        reset = 1'b1;
        repeat (10) step();

        value_in = 16'h1A3F;
        load = 1'b1;
        step();
        load = 1'b0;
        enable = 1'b1;
        ticks = 0;
        repeat (2) step();
        step();
        check("first_digit_an", {28'd0, an_n}, 32'hE);
        check("first_digit_seg", {25'd0, seg_n}, 32'h0E);
        repeat (46) step();
        check("tick_count_2_frames", ticks, 2);

        run_until_slot(1);
        value_in = 16'h0000;
        load = 1'b1;
        step();
        load = 1'b0;
        repeat (2 * FRAME) step();

        value_in = 16'($urandom);
        load = 1'b1;
        step();
        load = 1'b0;
        blank_mask = 4'b0101;
        repeat (2 * FRAME) step();
        blank_mask = 4'b0000;

        run_until_slot(2);
        step();
        enable = 1'b0;
        repeat (5) step();
        enable = 1'b1;
        repeat (FRAME) step();

        run_until_slot(3);
        reset = 1'b0;
        step();
        reset = 1'b1;
        repeat (FRAME) step();

        repeat (2000) begin
            value_in = 16'($urandom);
            load     = ($urandom_range(0, 15) == 0);
            if ($urandom_range(0, 31) == 0) blank_mask = 4'($urandom);
            enable   = ($urandom_range(0, 63) != 0);
            reset    = ($urandom_range(0, 255) != 0);
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
